// File: rtl/pipeline_calc_pkg.sv
// Shared constants and types for the pipelined calculator interface.
// The operand-issue side and the result collector both use these, so the
// latency and result width stay consistent on both ends.
package pipeline_calc_pkg;

    localparam int DATA_W = 5;
    localparam int LAT    = 3;

    typedef logic [DATA_W-1:0] result_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous first-word-fall-through FIFO.
// The head entry is visible on rd_data whenever the FIFO is not empty, and
// rd_data reads as zero when it is empty. A write is accepted when the FIFO
// is full only if a read happens in the same cycle, so occupancy is unchanged.
module result_fifo #(
    parameter int DATA_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_do_rd;
    logic              w_do_wr;

    assign empty   = (r_count == '0);
    assign full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_rd = rd_en & ~empty;
    assign w_do_wr = wr_en & (~full | w_do_rd);
    assign count   = r_count;
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    // Storage array; contents are only observable through the count-gated head.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Occupancy: simultaneous read and write leaves it unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_result_collector.sv
// Consumer end of the pipelined calculator: a valid delay line marks the
// cycle in which each issued operand set's result S is ready, the result is
// captured into a FWFT FIFO, and drops on a full FIFO are flagged and counted.
// Optional feature macro: RESULT_SUM_EN adds a running sum of captured results.
module pipeline_result_collector #(
    parameter int DATA_W = pipeline_calc_pkg::DATA_W,
    parameter int LAT    = pipeline_calc_pkg::LAT,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          s_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clr_ovf,
    output logic [7:0]                 drop_cnt,
`ifdef RESULT_SUM_EN
    output logic [15:0]                total_cnt,
    output logic [DATA_W+7:0]          res_sum
`else
    output logic [15:0]                total_cnt
`endif
);

    import pipeline_calc_pkg::*;

    // Valid/ready on the output port: a transfer happens on a rising edge
    // where out_valid and out_ready are both high; out_valid never drops and
    // out_data never changes until that transfer occurs.

    logic [LAT-1:0] r_vpipe;
    logic           w_cap;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic           w_wr;
    logic           w_drop;

    assign w_cap     = r_vpipe[LAT-1];
    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;
    assign w_wr      = w_cap & (~w_full | w_pop);
    assign w_drop    = w_cap & w_full & ~w_pop;

    // Valid delay line: one stage per pipeline cycle, so stage LAT-1 lines up with S.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= in_valid;
            for (int i = 1; i < LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
        end
    end

    result_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr),
        .wr_data (s_in),
        .rd_en   (w_pop),
        .rd_data (out_data),
        .full    (w_full),
        .empty   (w_empty),
        .count   (count)
    );

    // Sticky drop flag and saturating drop counter; a drop beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (w_drop) begin
            overflow <= 1'b1;
            if (clr_ovf)                drop_cnt <= 8'd1;
            else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    // Count of results actually written into the FIFO, wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_cnt <= '0;
        end else if (w_wr) begin
            total_cnt <= total_cnt + 16'd1;
        end
    end

`ifdef RESULT_SUM_EN
    // Running wrap-around sum of captured results; drops are excluded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_sum <= '0;
        end else if (w_wr) begin
            res_sum <= res_sum + {8'd0, s_in};
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_result_collector.sv
// Self-checking bench for pipeline_result_collector: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_pipeline_result_collector;

    localparam int DATA_W = 5;
    localparam int LAT    = 3;
    localparam int DEPTH  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] s_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        count;
    logic              overflow;
    logic              clr_ovf;
    logic [7:0]        drop_cnt;
    logic [15:0]       total_cnt;
`ifdef RESULT_SUM_EN
    logic [DATA_W+7:0] res_sum;
`endif

    pipeline_result_collector #(
        .DATA_W (DATA_W),
        .LAT    (LAT),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .s_in      (s_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .drop_cnt  (drop_cnt),
`ifdef RESULT_SUM_EN
        .total_cnt (total_cnt),
        .res_sum   (res_sum)
`else
        .total_cnt (total_cnt)
`endif
    );

    // ---------------- reference model / scoreboard ----------------
    logic [DATA_W-1:0] exp_q[$];
    int                issue_q[$];
    int                edge_n;
    logic              m_ovf;
    int                m_drop;
    int                m_total;
    int                m_sum;
    int                n_vec;
    int                n_err;
    logic [DATA_W-1:0] bv [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        issue_q.delete();
        m_ovf   = 1'b0;
        m_drop  = 0;
        m_total = 0;
        m_sum   = 0;
    endtask

    // One rising edge: an issue at edge k yields a capture at edge k+LAT.
    task automatic model_edge(input logic iv, input logic [DATA_W-1:0] s,
                              input logic rdy, input logic clr);
        bit cap;
        bit pop;
        bit drop;
        int sz;
        cap  = 0;
        drop = 0;
        if (issue_q.size() > 0 && issue_q[0] == edge_n - LAT) begin
            cap = 1;
            void'(issue_q.pop_front());
        end
        sz  = exp_q.size();
        pop = (sz > 0) && rdy;
        if (pop) void'(exp_q.pop_front());
        if (cap) begin
            if (sz < DEPTH || pop) begin
                exp_q.push_back(s);
                m_total = (m_total + 1) % 65536;
                m_sum   = (m_sum + int'(s)) % (1 << (DATA_W + 8));
            end else begin
                drop = 1;
            end
        end
        if (drop) begin
            m_ovf  = 1'b1;
            m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        if (iv) issue_q.push_back(edge_n);
        edge_n++;
    endtask

    task automatic check_all();
        logic [DATA_W-1:0] head;
        head = '0;
        if (exp_q.size() > 0) head = exp_q[0];
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("out_data",  32'(out_data),  32'(head));
        check("count",     32'(count),     32'(exp_q.size()));
        check("overflow",  32'(overflow),  32'(m_ovf));
        check("drop_cnt",  32'(drop_cnt),  32'(m_drop));
        check("total_cnt", 32'(total_cnt), 32'(m_total));
`ifdef RESULT_SUM_EN
        check("res_sum",   32'(res_sum),   32'(m_sum));
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic iv, input logic [DATA_W-1:0] s,
                        input logic rdy, input logic clr);
        @(negedge clk);
        in_valid  = iv;
        s_in      = s;
        out_ready = rdy;
        clr_ovf   = clr;
        @(posedge clk);
        model_edge(iv, s, rdy, clr);
        #1;
        check_all();
    endtask

    // Issue n back-to-back operand sets; bv[j] appears on s_in at its capture edge.
    task automatic burst(input int n, input logic rdy);
        for (int k = 0; k < n + LAT; k++) begin
            logic [DATA_W-1:0] s;
            s = DATA_W'($urandom_range(0, 31));
            if (k >= LAT && k - LAT < n) s = bv[k-LAT];
            step(k < n, s, rdy, 1'b0);
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_count",     32'(count),     32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_drop_cnt",  32'(drop_cnt),  32'd0);
        check("rst_total_cnt", 32'(total_cnt), 32'd0);
        model_clear();
        repeat (2) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            s_in      = DATA_W'($urandom_range(0, 31));
            out_ready = 1'($urandom_range(0, 1));
            clr_ovf   = 1'($urandom_range(0, 1));
            @(posedge clk);
            edge_n++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        reset     = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + LAT + 2; k++) step(1'b0, DATA_W'($urandom_range(0, 31)), 1'b1, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DATA_W-1:0] exp_order [4];
        n_vec  = 0;
        n_err  = 0;
        edge_n = 0;
        model_clear();

        // Power-on reset with random inputs.
        reset     = 1'b0;
        in_valid  = 1'($urandom_range(0, 1));
        s_in      = DATA_W'($urandom_range(0, 31));
        out_ready = 1'($urandom_range(0, 1));
        clr_ovf   = 1'($urandom_range(0, 1));
        #16;
        check("por_out_valid", 32'(out_valid), 32'd0);
        check("por_out_data",  32'(out_data),  32'd0);
        check("por_count",     32'(count),     32'd0);
        check("por_overflow",  32'(overflow),  32'd0);
        check("por_total_cnt", 32'(total_cnt), 32'd0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        reset     = 1'b1;

        // Fill and overflow: five captures into a four-entry FIFO.
        bv[0] = 5; bv[1] = 9; bv[2] = 12; bv[3] = 30; bv[4] = 7;
        burst(5, 1'b0);
        check("fill_count",    32'(count),     32'd4);
        check("fill_overflow", 32'(overflow),  32'd1);
        check("fill_drop_cnt", 32'(drop_cnt),  32'd1);
        check("fill_total",    32'(total_cnt), 32'd4);
        exp_order[0] = 5; exp_order[1] = 9; exp_order[2] = 12; exp_order[3] = 30;
        for (int i = 0; i < 4; i++) begin
            check("fill_drain_data", 32'(out_data), 32'(exp_order[i]));
            step(1'b0, DATA_W'($urandom_range(0, 31)), 1'b1, 1'b0);
        end
        check("fill_drain_empty", 32'(out_valid), 32'd0);

        // Clear alone.
        step(1'b0, 5'd0, 1'b0, 1'b1);
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_drop_cnt", 32'(drop_cnt), 32'd0);

        // Latency: single issue, S valid only at the third edge after issue.
        step(1'b1, DATA_W'($urandom_range(0, 31)), 1'b0, 1'b0);
        step(1'b0, 5'd0,  1'b0, 1'b0);
        step(1'b0, 5'd31, 1'b0, 1'b0);
        check("lat_not_yet", 32'(out_valid), 32'd0);
        step(1'b0, 5'd17, 1'b0, 1'b0);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data",  32'(out_data),  32'd17);
        step(1'b0, 5'd31, 1'b0, 1'b0);
        check("lat_count", 32'(count),    32'd1);
        check("lat_hold",  32'(out_data), 32'd17);
        drain();

        // Full FIFO with a pop in the capture cycle.
        bv[0] = 1; bv[1] = 2; bv[2] = 3; bv[3] = 4;
        burst(4, 1'b0);
        step(1'b1, 5'd0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 1'b0, 1'b0);
        step(1'b0, 5'd8, 1'b1, 1'b0);
        check("fullpop_count",    32'(count),    32'd4);
        check("fullpop_overflow", 32'(overflow), 32'd0);
        check("fullpop_head",     32'(out_data), 32'd2);

        // Clear racing a drop: the drop wins.
        step(1'b1, 5'd0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 1'b0, 1'b0);
        step(1'b0, 5'd21, 1'b0, 1'b1);
        check("race_overflow", 32'(overflow), 32'd1);
        check("race_drop_cnt", 32'(drop_cnt), 32'd1);
        step(1'b0, 5'd0, 1'b0, 1'b1);
        check("race_clr_ovf",  32'(overflow), 32'd0);
        check("race_clr_drop", 32'(drop_cnt), 32'd0);
        exp_order[0] = 2; exp_order[1] = 3; exp_order[2] = 4; exp_order[3] = 8;
        for (int i = 0; i < 4; i++) begin
            check("fullpop_drain", 32'(out_data), 32'(exp_order[i]));
            step(1'b0, DATA_W'($urandom_range(0, 31)), 1'b1, 1'b0);
        end
        check("fullpop_empty", 32'(out_valid), 32'd0);

        // Randomized traffic with periodic back-pressure and one mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            logic rdy;
            rdy = ((i % 60) < 20) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
            step(1'($urandom_range(0, 1)), DATA_W'($urandom_range(0, 31)), rdy,
                 1'($urandom_range(0, 15) == 0));
            if (i == 200) do_reset();
        end

        // Running sum: four captures plus one dropped result.
        do_reset();
        bv[0] = 6; bv[1] = 8; bv[2] = 10; bv[3] = 3; bv[4] = 9;
        burst(5, 1'b0);
        check("sum_drop_cnt", 32'(drop_cnt), 32'd1);
        check("sum_count",    32'(count),    32'd4);
`ifdef RESULT_SUM_EN
        check("sum_value",    32'(res_sum),  32'd27);
`endif
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/pipeline_result_collector.md
Name: pipeline_result_collector

Overview:
- Consumer end of the pipelined calculator interface. It tracks which issued operand sets are still in flight and captures the pipeline result `S` exactly `LAT` cycles after issue.
- Captured results are buffered in a small FIFO and presented on a valid/ready output port.
- Sits downstream of `pipeline_calculate`; the operand issuer drives `in_valid` alongside A..E.

Parameters:
- DATA_W, 5, width of pipeline result `S` / captured data.
- LAT, 3, pipeline latency in cycles from operand issue edge to valid `S`; legal range 1..8.
- DEPTH, 4, result FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set issued to the pipeline this cycle.
- s_in  input  DATA_W  pipeline result `S`.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  downstream accepts head.
- out_data  output  DATA_W  FIFO head, first-word-fall-through.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  output  1  sticky; a result was dropped.
- clr_ovf  input  1  synchronous clear of `overflow` and `drop_cnt`.
- drop_cnt  output  8  dropped results, saturates at 255.
- total_cnt  output  16  results captured, wraps mod 2^16.

Behaviour:
- Reset (`reset`=0, async): clears the delay line, FIFO pointers, `count`, `overflow`, `drop_cnt` and `total_cnt`. Outputs `out_valid`=0 and `out_data`=0. In-flight results are discarded.
- Delay line: `vpipe[0]` <= `in_valid`, `vpipe[i]` <= `vpipe[i-1]`. The capture strobe `cap` = `vpipe[LAT-1]`. With `in_valid` high before edge N, `s_in` is sampled at edge N+LAT.
- `s_in` is ignored whenever `cap`=0.
- Pop = `out_valid` & `out_ready`; the head advances at that edge. `out_valid` = (`count` != 0).
- `out_data` holds its value while `out_valid`=1 and `out_ready`=0.
- Capture when `cap`=1:
  - If `count` < DEPTH, or a pop happens in the same cycle, write `s_in` at the tail and increment `total_cnt`.
  - Otherwise drop the result: set `overflow`, increment `drop_cnt` (saturating at 255), and leave the FIFO untouched.
- Simultaneous capture and pop: `count` is unchanged. This holds when full and when at `count`=1.
- Pop on empty cannot occur, because `out_valid`=0.
- `clr_ovf` in the same cycle as a drop: set wins (`overflow`=1, `drop_cnt`=1).
- Pointers wrap mod DEPTH. Results leave in strict capture order.
- Back-to-back `in_valid` produces one capture per cycle, with no bubbles.

Optional Feature:
- Macro `RESULT_SUM_EN`.
- Defined: adds output `res_sum` [DATA_W+7:0], cleared on reset.
  - On each successful capture, `res_sum` += `s_in`, wrapping.
  - Dropped results are not summed.
  - Updates at the capture edge.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package `pipeline_calc_pkg`:
  - `DATA_W`=5 and `LAT`=3 constants.
  - `result_t` typedef (`logic [DATA_W-1:0]`).
  - Shared with the operand-issue side.
- Sub-module `result_fifo`: synchronous FWFT FIFO with `wr_en`, `rd_en`, `full`, `empty`, `count`, parameterised by DATA_W and DEPTH.
- Top level keeps the delay line, counters and overflow logic.

Test Plan:
- Reset: hold `reset`=0 for 15 time units with random inputs -> `out_valid`=0, `out_data`=0, `count`=0, `overflow`=0, `total_cnt`=0. Drive `reset`=0 mid-stream -> all of these clear immediately, without waiting for a clock edge.
- Latency: `in_valid` pulse before edge 0; `s_in`=17 only at edge 3, `s_in`=31 at edges 2 and 4 -> exactly one entry, `out_data`=17, `out_valid` high after edge 3.
- Fill/overflow: `out_ready`=0, five consecutive valids with `s_in`=5,9,12,30,7 -> `count`=4, `overflow`=1, `drop_cnt`=1, `total_cnt`=4. Then `out_ready`=1 -> outputs 5,9,12,30, then `out_valid`=0.
- Full with simultaneous pop: FIFO holds 1,2,3,4; `out_ready`=1 during capture of 8 -> no overflow, `count` stays 4, drain order 2,3,4,8.
- Clear race: `clr_ovf`=1 in the same cycle as a drop -> `overflow`=1, `drop_cnt`=1. A later `clr_ovf` alone -> both 0.
- `RESULT_SUM_EN`: capture 6,8,10,3 plus one dropped result of 9 -> `res_sum`=27. Rebuild without the macro -> the port is absent and the other tests pass unchanged.
